lut_chain_frac_cfg: RTL and testbench

- Parametrised successor to the two-slice S_XX fracturable LUT. Provides NUM_LUTS chained, individually fracturable LUT slices.
- Configuration arrives over a serial valid/ready bitstream into a shadow register and is applied atomically on commit, so a reconfiguration never produces a half-loaded table.
- Sits in the CLB between the input crossbar and the output muxes/flops; the config bitstream comes from the CLB config chain.

---
 rtl/lut_chain_frac_cfg_pkg.sv | 20 ++
 rtl/lut_chain_frac_cfg_if.sv | 23 ++
 rtl/lut_chain_frac_cfg_slice.sv | 30 +++
 rtl/lut_chain_frac_cfg.sv | 129 ++++++++++++
 tb/tb_lut_chain_frac_cfg.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lut_chain_frac_cfg_pkg.sv
// lut_cfg_pkg: loader FSM encoding and per-slice config field layout
// shared by the lut_chain_frac_cfg files.
package lut_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        LOADED = 2'd2
    } cfg_state_e;

    // Slice field: [MEM_SIZE-1:0] table, then frac, then split.
    function automatic int frac_ofs(input int mem_size);
        return mem_size;
    endfunction

    function automatic int split_ofs(input int mem_size);
        return mem_size + 1;
    endfunction

endpackage

// File: rtl/lut_chain_frac_cfg_if.sv
// lut_chain_frac_cfg_if: serial config bitstream handshake.
// master drives the stream, slave is the LUT chain loader.
interface lut_chain_frac_cfg_if;

    logic cfg_start;
    logic cfg_bit;
    logic cfg_valid;
    logic cfg_ready;
    logic cfg_commit;
    logic cfg_loaded;
    logic cfg_err;

    modport master (
        output cfg_start, cfg_bit, cfg_valid, cfg_commit,
        input  cfg_ready, cfg_loaded, cfg_err
    );

    modport slave (
        input  cfg_start, cfg_bit, cfg_valid, cfg_commit,
        output cfg_ready, cfg_loaded, cfg_err
    );

endinterface

// File: rtl/lut_chain_frac_cfg_slice.sv
// lut_slice_frac: combinational read of one fracturable LUT slice.
// lo/hi read the two table halves; full picks between them.
module lut_slice_frac #(
    parameter int INPUTS = 4
) (
    input  logic [2**INPUTS-1:0] tbl,
    input  logic                 frac,
    input  logic                 split,
    input  logic [INPUTS-1:0]    addr,
    input  logic                 chain_in,
    output logic                 full,
    output logic                 hi,
    output logic                 lo
);

    logic [INPUTS-1:0] idx_lo;
    logic [INPUTS-1:0] idx_hi;
    logic              top;

    // Lower half and upper half share the low address bits.
    always_comb begin
        idx_lo = {1'b0, addr[INPUTS-2:0]};
        idx_hi = {1'b1, addr[INPUTS-2:0]};
        lo     = tbl[idx_lo];
        hi     = tbl[idx_hi];
        top    = split ? addr[INPUTS-1] : chain_in;
        full   = frac ? lo : (top ? hi : lo);
    end

endmodule

// File: rtl/lut_chain_frac_cfg.sv
// lut_chain_frac_cfg: NUM_LUTS chained fracturable LUT slices with a
// shadowed serial config loader. Optional: LUT_CFG_READBACK_EN.
module lut_chain_frac_cfg
    import lut_cfg_pkg::*;
#(
    parameter int INPUTS   = 4,
    parameter int NUM_LUTS = 2
) (
    input  logic                       cclk,
    input  logic                       crst_n,
    input  logic [NUM_LUTS*INPUTS-1:0] addr,
    input  logic                       chain_in,
    output logic [3*NUM_LUTS-1:0]      out,
    output logic                       chain_out,
`ifdef LUT_CFG_READBACK_EN
    input  logic                       cfg_rb_en,
    output logic                       cfg_rb,
`endif
    lut_chain_frac_cfg_if.slave        cfg
);

    localparam int MEM_SIZE   = 2**INPUTS;
    localparam int SLICE_BITS = MEM_SIZE + 2;
    localparam int CFG_BITS   = NUM_LUTS * SLICE_BITS;
    localparam int FRAC_OFS   = frac_ofs(MEM_SIZE);
    localparam int SPLIT_OFS  = split_ofs(MEM_SIZE);
    localparam int CNT_W      = $clog2(CFG_BITS + 1);

    cfg_state_e          state_q;
    cfg_state_e          state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [CFG_BITS-1:0] shadow_q;
    logic [CFG_BITS-1:0] active_q;
    logic                err_q;
    logic                accept;
    logic                commit_ok;
    logic                last_bit;

    // Loader state register.
    always_ff @(posedge cclk or negedge crst_n) begin
        if (!crst_n) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next state and handshake outputs; a start overrides everything.
    always_comb begin
        state_d        = state_q;
        cfg.cfg_ready  = 1'b0;
        cfg.cfg_loaded = 1'b0;
        commit_ok      = 1'b0;
        accept         = 1'b0;
        last_bit       = (cnt_q == CNT_W'(CFG_BITS - 1));
        unique case (state_q)
            IDLE: ;
            SHIFT: begin
                cfg.cfg_ready = 1'b1;
                accept        = cfg.cfg_valid && !cfg.cfg_start;
                if (accept && last_bit) state_d = LOADED;
            end
            LOADED: begin
                cfg.cfg_loaded = 1'b1;
                commit_ok      = cfg.cfg_commit;
                if (cfg.cfg_commit) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (cfg.cfg_start) state_d = SHIFT;
    end

    // Accepted-bit counter, restarted by every cfg_start.
    always_ff @(posedge cclk or negedge crst_n) begin
        if (!crst_n)            cnt_q <= '0;
        else if (cfg.cfg_start) cnt_q <= '0;
        else if (accept)        cnt_q <= cnt_q + 1'b1;
    end

    // Shadow shifts MSB-first; never cleared by a restart.
    always_ff @(posedge cclk or negedge crst_n) begin
        if (!crst_n)     shadow_q <= '0;
        else if (accept) shadow_q <= {shadow_q[CFG_BITS-2:0], cfg.cfg_bit};
    end

    // Active config changes atomically on a valid commit.
    always_ff @(posedge cclk or negedge crst_n) begin
        if (!crst_n)        active_q <= '0;
        else if (commit_ok) active_q <= shadow_q;
`ifdef LUT_CFG_READBACK_EN
        else if (state_q == IDLE && cfg_rb_en)
            active_q <= {active_q[CFG_BITS-2:0], active_q[CFG_BITS-1]};
`endif
    end

    // Sticky error: commit without a complete load.
    always_ff @(posedge cclk or negedge crst_n) begin
        if (!crst_n)                 err_q <= 1'b0;
        else if (cfg.cfg_start)      err_q <= 1'b0;
        else if (cfg.cfg_commit && state_q != LOADED)
                                     err_q <= 1'b1;
    end

    assign cfg.cfg_err = err_q;

`ifdef LUT_CFG_READBACK_EN
    assign cfg_rb = active_q[CFG_BITS-1];
`endif

    logic [NUM_LUTS:0] chain;
    assign chain[0]  = chain_in;
    assign chain_out = chain[NUM_LUTS];

    for (genvar k = 0; k < NUM_LUTS; k++) begin : g_slice
        logic [SLICE_BITS-1:0] fld;
        assign fld = active_q[k*SLICE_BITS +: SLICE_BITS];

        lut_slice_frac #(.INPUTS(INPUTS)) u_slice (
            .tbl      (fld[MEM_SIZE-1:0]),
            .frac     (fld[FRAC_OFS]),
            .split    (fld[SPLIT_OFS]),
            .addr     (addr[k*INPUTS +: INPUTS]),
            .chain_in (chain[k]),
            .full     (chain[k+1]),
            .hi       (out[3*k+1]),
            .lo       (out[3*k])
        );

        assign out[3*k+2] = chain[k+1];
    end

endmodule

// File: tb/tb_lut_chain_frac_cfg.sv
// tb_lut_chain_frac_cfg: randomized self-checking bench against a
// behavioural model of the loader protocol and LUT arithmetic.
module tb_lut_chain_frac_cfg;

    localparam int CFG_BITS = 36;

    logic       cclk = 1'b0;
    logic       crst_n = 1'b0;
    logic [7:0] addr = '0;
    logic       chain_in = 1'b0;
    logic [5:0] out;
    logic       chain_out;
`ifdef LUT_CFG_READBACK_EN
    logic       cfg_rb;
`endif

    int errors = 0;
    int checks = 0;

    logic [35:0] m_active;
    logic [35:0] m_shadow;
    int          m_cnt;
    logic        m_loaded;
    logic        m_err;

    lut_chain_frac_cfg_if cfg_if();

    always #5 cclk = ~cclk;

    lut_chain_frac_cfg #(.INPUTS(4), .NUM_LUTS(2)) dut (
        .cclk      (cclk),
        .crst_n    (crst_n),
        .addr      (addr),
        .chain_in  (chain_in),
        .out       (out),
        .chain_out (chain_out),
`ifdef LUT_CFG_READBACK_EN
        .cfg_rb_en (1'b0),
        .cfg_rb    (cfg_rb),
`endif
        .cfg       (cfg_if.slave)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [17:0] mk_slice(input logic split,
        input logic frac, input logic [15:0] tbl);
        return {split, frac, tbl};
    endfunction

    // {chain_out, out} from the slice rules, using integer arithmetic.
    function automatic logic [6:0] model_out(input logic [35:0] act,
        input logic [7:0] a, input logic cin);
        logic [6:0]  r;
        logic [35:0] f;
        int c, sa, t, split, frac, low, lo, hi, top, full;
        r = '0;
        c = int'(cin);
        for (int k = 0; k < 2; k++) begin
            f     = act >> (18 * k);
            t     = int'(f[15:0]);
            frac  = int'(f[16]);
            split = int'(f[17]);
            sa    = (int'(a) >> (4 * k)) % 16;
            low   = sa % 8;
            lo    = (t >> low) % 2;
            hi    = (t >> (8 + low)) % 2;
            top   = (split != 0) ? sa / 8 : c;
            full  = (frac != 0) ? lo : ((top != 0) ? hi : lo);
            r[3*k]   = (lo != 0);
            r[3*k+1] = (hi != 0);
            r[3*k+2] = (full != 0);
            c = full;
        end
        r[6] = (c != 0);
        return r;
    endfunction

    task automatic tick();
        @(posedge cclk);
        #1;
    endtask

    task automatic check_out(input string tag);
        chk(tag, {chain_out, out}, model_out(m_active, addr, chain_in));
    endtask

    task automatic check_flags(input string tag);
        chk({tag, "_loaded"}, cfg_if.cfg_loaded, m_loaded);
        chk({tag, "_err"}, cfg_if.cfg_err, m_err);
    endtask

    task automatic do_start();
        cfg_if.cfg_start = 1'b1;
        tick();
        cfg_if.cfg_start = 1'b0;
        m_cnt = 0;
        m_loaded = 1'b0;
        m_err = 1'b0;
    endtask

    task automatic do_commit();
        cfg_if.cfg_commit = 1'b1;
        tick();
        cfg_if.cfg_commit = 1'b0;
        if (m_loaded) begin
            m_active = m_shadow;
            m_loaded = 1'b0;
        end else begin
            m_err = 1'b1;
        end
    endtask

    // Send the first n bits of s, MSB first, with random valid gaps.
    task automatic send_bits(input logic [35:0] s, input int n);
        int got = 0;
        int budget = 0;
        while (got < n && budget < 2000) begin
            cfg_if.cfg_valid = 1'($urandom_range(0, 1));
            cfg_if.cfg_bit = cfg_if.cfg_valid ? s[35-got] : 1'($urandom);
            #2;
            chk("ready_shift", cfg_if.cfg_ready, 1'b1);
            tick();
            if (cfg_if.cfg_valid) begin
                m_shadow = {m_shadow[34:0], s[35-got]};
                m_cnt++;
                if (m_cnt == CFG_BITS) m_loaded = 1'b1;
                got++;
            end
            budget++;
        end
        cfg_if.cfg_valid = 1'b0;
        if (got < n) chk("load_timeout", got, n);
    endtask

    task automatic rand_outs(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            addr = 8'($urandom);
            chain_in = 1'($urandom);
            #1;
            check_out(tag);
        end
    endtask

    function automatic logic [35:0] rnd36();
        logic [35:0] r;
        r = {4'($urandom), 32'($urandom)};
        return r;
    endfunction

    logic [35:0] cfg_a, cfg_b, cfg_c, cfg_d;

    initial begin
        cfg_if.cfg_start  = 1'b0;
        cfg_if.cfg_bit    = 1'b0;
        cfg_if.cfg_valid  = 1'b0;
        cfg_if.cfg_commit = 1'b0;
        m_active = '0;
        m_shadow = '0;
        m_cnt    = 0;
        m_loaded = 1'b0;
        m_err    = 1'b0;

        repeat (3) @(posedge cclk);
        #1 crst_n = 1'b1;
        #2;
        chk("rst_ready", cfg_if.cfg_ready, 1'b0);
        check_flags("rst");
        for (int i = 0; i < 4; i++) begin
            addr = 8'($urandom);
            chain_in = 1'($urandom);
            #1;
            chk("rst_out", {chain_out, out}, 7'b0);
        end
        tick();

        // AND4 in both slices.
        cfg_a = {mk_slice(1'b1, 1'b0, 16'h8000),
                 mk_slice(1'b1, 1'b0, 16'h8000)};
        do_start();
        send_bits(cfg_a, 36);
        #1;
        chk("full_ready", cfg_if.cfg_ready, 1'b0);
        check_flags("full");
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_bit = 1'b1;
        tick();
        tick();
        cfg_if.cfg_valid = 1'b0;
        addr = 8'hFF;
        #1;
        chk("pre_commit", {chain_out, out}, 7'b0);
        do_commit();
        addr = 8'hFF;
        #1;
        chk("and4_ff", {chain_out, out}, 7'b1_110_110);
        check_flags("commit");
        addr = 8'hF7;
        #1;
        chk("and4_f7_full0", out[2], 1'b0);
        check_out("and4_f7");
        rand_outs("and4_rand", 8);
        tick();

        // Chained slice1 tracks full0; then frac forces lo.
        cfg_b = {mk_slice(1'b0, 1'b0, 16'hFF00),
                 mk_slice(1'b1, 1'b0, 16'h8000)};
        do_start();
        send_bits(cfg_b, 36);
        do_commit();
        for (int i = 0; i < 8; i++) begin
            addr = 8'($urandom);
            if (i % 2 == 0) addr[3:0] = 4'hF;
            #1;
            chk("chain_full1", out[5], addr[3:0] == 4'hF);
            check_out("chain");
        end
        cfg_c = {mk_slice(1'b0, 1'b1, 16'hFF00),
                 mk_slice(1'b1, 1'b0, 16'h8000)};
        do_start();
        send_bits(cfg_c, 36);
        do_commit();
        for (int i = 0; i < 4; i++) begin
            addr = 8'($urandom);
            #1;
            chk("frac_full1", out[5], 1'b0);
        end
        tick();

        // Abort a partial load; only the new stream becomes active.
        cfg_d = rnd36();
        do_start();
        send_bits(rnd36(), 20);
        do_start();
        send_bits(cfg_d, 36);
        rand_outs("hold_old", 4);
        do_commit();
        rand_outs("after_abort", 8);

        // Commit during SHIFT flags an error, output unchanged.
        do_start();
        send_bits(rnd36(), 5);
        do_commit();
        #1;
        check_flags("shift_commit");
        rand_outs("shift_commit_out", 4);
        do_start();
        #1;
        check_flags("err_clear");

        // Simultaneous start and commit in LOADED.
        send_bits(rnd36(), 36);
        cfg_if.cfg_start = 1'b1;
        cfg_if.cfg_commit = 1'b1;
        tick();
        cfg_if.cfg_start = 1'b0;
        cfg_if.cfg_commit = 1'b0;
        m_active = m_shadow;
        m_cnt = 0;
        m_loaded = 1'b0;
        m_err = 1'b0;
        #1;
        chk("startcommit_ready", cfg_if.cfg_ready, 1'b1);
        check_flags("startcommit");
        rand_outs("startcommit_out", 6);

        // Random configs.
        for (int r = 0; r < 3; r++) begin
            send_bits(rnd36(), 36);
            do_commit();
            rand_outs("rand_cfg", 10);
            do_start();
        end
        send_bits(cfg_a, 36);
        do_commit();

        // Commit in IDLE.
        do_commit();
        #1;
        check_flags("idle_commit");
        rand_outs("idle_commit_out", 4);
        tick();

        // Async reset during a load.
        do_start();
        send_bits(rnd36(), 10);
        addr = 8'hFF;
        chain_in = 1'b1;
        #1;
        check_out("pre_rst");
        crst_n = 1'b0;
        #1;
        chk("async_rst_out", {chain_out, out}, 7'b0);
        m_active = '0;
        m_shadow = '0;
        m_cnt = 0;
        m_loaded = 1'b0;
        m_err = 1'b0;
        repeat (2) @(posedge cclk);
        #1 crst_n = 1'b1;
        #1;
        chk("post_rst_ready", cfg_if.cfg_ready, 1'b0);
        check_flags("post_rst");
        tick();
        chk("post_rst_idle", cfg_if.cfg_ready, 1'b0);
        do_commit();
        #1;
        rand_outs("post_rst_out", 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
